// File: rtl/mips_tb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : mips_tb_pkg                                                  |
// | Description : Shared types and constants for the MIPS program monitor.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package mips_tb_pkg;

   // Monitor sequencing states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } mon_state_t;

   // CPU reset vector, where the program ROM is normally mapped
   localparam logic [31:0] MIPS_RESET_VECTOR = 32'hBFC00000;

   // All-zero word decodes as sll $0,$0,0, i.e. a no-op
   localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

endpackage : mips_tb_pkg
`default_nettype wire

// File: rtl/mips_instr_rom.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mips_instr_rom                                               |
// | Description : Loadable DEPTH-word instruction store with a byte-address    |
// |               window decode. Out-of-window or misaligned reads return NOP. |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module mips_instr_rom
   import mips_tb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = MIPS_RESET_VECTOR,
   parameter int          DEPTH     = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [31:0]              wr_data,
   input  logic [31:0]              rd_addr,
   output logic [31:0]              rd_data
);

   localparam int          AW        = $clog2(DEPTH);
   localparam logic [31:0] WIN_BYTES = 32'(4 * DEPTH);

   logic [31:0] mem_q [DEPTH];
   logic [31:0] offset;
   logic        hit;

   // Storage: cleared to NOP on reset, written one word per load cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= MIPS_NOP;
         end
      end else if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Window decode: the lower-bound test stops addresses below BASE from
   // wrapping into the window, the upper-bound test stops aliasing above it
   always_comb begin
      offset  = rd_addr - BASE_ADDR;
      hit     = (rd_addr >= BASE_ADDR) && (offset < WIN_BYTES) && (rd_addr[1:0] == 2'b00);
      rd_data = hit ? mem_q[offset[AW+1:2]] : MIPS_NOP;
   end

endmodule : mips_instr_rom
`default_nettype wire

// File: rtl/mips_prog_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mips_prog_monitor                                            |
// | Description : Program ROM plus completion checker for MIPS CPU benches.    |
// |               Serves instructions, detects program end, compares $v0 and   |
// |               reports pass/fail with an enabled-cycle count.               |
// |               Optional timeout: define MIPS_MON_TIMEOUT_EN.                |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module mips_prog_monitor
   import mips_tb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = MIPS_RESET_VECTOR,
   parameter int          DEPTH      = 64,
   parameter logic [31:0] HALT_ADDR  = 32'h0000_0000,
   parameter int          MAX_CYCLES = 1000,
   parameter int          CNT_W      = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clk_enable,
   input  logic                     active,
   input  logic [31:0]              instr_address,
   output logic [31:0]              instr_readdata,
   input  logic [31:0]              register_v0,
   input  logic                     load_en,
   input  logic [$clog2(DEPTH)-1:0] load_addr,
   input  logic [31:0]              load_data,
   input  logic                     start,
   input  logic [31:0]              expected_v0,
   output logic                     done,
   output logic                     pass,
   output logic                     fail,
   output logic [CNT_W-1:0]         cycle_count
);

`ifdef MIPS_MON_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MAX_CYCLES - 1);
`endif

   mon_state_t       state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic             fail_q, fail_d;
   logic [CNT_W-1:0] count_inc;
   logic             halt_hit;
   logic             rom_wr;

   // ROM is only writable while no program is being observed
   assign rom_wr = load_en && ((state_q == IDLE) || (state_q == DONE));

   mips_instr_rom #(
      .BASE_ADDR (BASE_ADDR),
      .DEPTH     (DEPTH)
   ) u_rom (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (rom_wr),
      .wr_addr (load_addr),
      .wr_data (load_data),
      .rd_addr (instr_address),
      .rd_data (instr_readdata)
   );

   // Next-state logic: sequencing, saturating counter and result capture
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      done_d    = done_q;
      pass_d    = pass_q;
      fail_d    = fail_q;
      count_inc = (count_q == '1) ? count_q : count_q + 1'b1;
      halt_hit  = (instr_address == HALT_ADDR) || !active;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               count_d = '0;
            end
         end
         RUN: begin
            // A stalled CPU freezes everything, including the halt test
            if (clk_enable) begin
               count_d = count_inc;
               if (halt_hit) begin
                  state_d = CHECK;
               end
`ifdef MIPS_MON_TIMEOUT_EN
               else if (count_inc == TIMEOUT_CNT) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  pass_d  = 1'b0;
                  fail_d  = 1'b1;
               end
`endif
            end
         end
         CHECK: begin
            pass_d  = (register_v0 == expected_v0);
            fail_d  = (register_v0 != expected_v0);
            done_d  = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            if (start) begin
               state_d = RUN;
               count_d = '0;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               fail_d  = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and result registers, asynchronously cleared
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
      end
   end

   assign done        = done_q;
   assign pass        = pass_q;
   assign fail        = fail_q;
   assign cycle_count = count_q;

endmodule : mips_prog_monitor
`default_nettype wire

// File: tb/tb_mips_prog_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mips_prog_monitor                                         |
// | Description : Directed self-checking bench for mips_prog_monitor. The      |
// |               bench plays the CPU: it walks fetch addresses and drives $v0.|
// |               Timeout scenario compiled only with MIPS_MON_TIMEOUT_EN.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_mips_prog_monitor;

   localparam logic [31:0] BASE  = 32'hBFC00000;
   localparam int          DEPTH = 64;
   localparam int          AW    = 6;
   localparam int          CNT_W = 16;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              clk_enable = 1'b0;
   logic              active = 1'b0;
   logic [31:0]       instr_address = 32'h0;
   logic [31:0]       instr_readdata;
   logic [31:0]       register_v0 = 32'h0;
   logic              load_en = 1'b0;
   logic [AW-1:0]     load_addr = '0;
   logic [31:0]       load_data = 32'h0;
   logic              start = 1'b0;
   logic [31:0]       expected_v0 = 32'h0;
   logic              done, pass, fail;
   logic [CNT_W-1:0]  cycle_count;

   int vectors = 0;
   int errors  = 0;

   // addiu $4,$0,-2 / sll $4,$4,16 / addiu $5,$0,16 / addiu $5,$5,7 /
   // addu $2,$4,$5 / jr $0 / nop / nop   -> $v0 = 0xFFFE0017
   logic [31:0] prog [8] = '{32'h2404FFFE, 32'h00042400, 32'h24050010, 32'h24A50007,
                             32'h00851021, 32'h00000008, 32'h00000000, 32'h00000000};

   mips_prog_monitor #(
      .BASE_ADDR  (BASE),
      .DEPTH      (DEPTH),
      .HALT_ADDR  (32'h0),
      .MAX_CYCLES (20),
      .CNT_W      (CNT_W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .clk_enable     (clk_enable),
      .active         (active),
      .instr_address  (instr_address),
      .instr_readdata (instr_readdata),
      .register_v0    (register_v0),
      .load_en        (load_en),
      .load_addr      (load_addr),
      .load_data      (load_data),
      .start          (start),
      .expected_v0    (expected_v0),
      .done           (done),
      .pass           (pass),
      .fail           (fail),
      .cycle_count    (cycle_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input int idx, input logic [31:0] w);
      load_en   = 1'b1;
      load_addr = AW'(idx);
      load_data = w;
      tick();
      load_en   = 1'b0;
   endtask

   task automatic start_run();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Walks the 8-word program then fetches the halt address; ends in DONE
   task automatic run_program();
      clk_enable  = 1'b1;
      active      = 1'b1;
      register_v0 = 32'h0;
      for (int i = 0; i < 8; i++) begin
         instr_address = BASE + 32'(4 * i);
         if (i == 4) register_v0 = 32'hFFFE0017;
         #1;
         vectors++;
         if (instr_readdata !== prog[i]) begin
            errors++;
            $display("FAIL fetch[%0d]: got %h want %h", i, instr_readdata, prog[i]);
         end
         tick();
      end
      instr_address = 32'h0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      instr_address = BASE;
      #1;
      vectors++;
      if ({done, pass, fail} !== 3'b000 || cycle_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_state: got d/p/f=%b%b%b cnt=%0d want 000 cnt=0", done, pass, fail, cycle_count);
      end
      vectors++;
      if (instr_readdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_rom: got %h want 00000000", instr_readdata);
      end
   endtask

   task automatic test_addu_pass();
      for (int i = 0; i < 8; i++) load_word(i, prog[i]);
      expected_v0 = 32'hFFFE0017;
      start_run();
      run_program();
      vectors++;
      if ({done, pass, fail} !== 3'b110 || cycle_count !== 16'd9) begin
         errors++;
         $display("FAIL addu_pass: got d/p/f=%b%b%b cnt=%0d want 110 cnt=9", done, pass, fail, cycle_count);
      end
   endtask

   task automatic test_addu_fail();
      expected_v0 = 32'h0;
      start_run();
      vectors++;
      if ({done, pass, fail} !== 3'b000 || cycle_count !== 16'd0) begin
         errors++;
         $display("FAIL restart_clear: got d/p/f=%b%b%b cnt=%0d want 000 cnt=0", done, pass, fail, cycle_count);
      end
      run_program();
      vectors++;
      if ({done, pass, fail} !== 3'b101 || cycle_count !== 16'd9) begin
         errors++;
         $display("FAIL addu_fail: got d/p/f=%b%b%b cnt=%0d want 101 cnt=9", done, pass, fail, cycle_count);
      end
   endtask

   task automatic test_fetch_window();
      logic [31:0] addrs [5];
      logic [31:0] exp   [5];
      load_word(63, 32'hDEADBEEF);
      addrs = '{BASE + 32'd252, BASE + 32'd256, BASE + 32'd2, BASE - 32'd4, BASE + 32'd4};
      exp   = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h00042400};
      for (int i = 0; i < 5; i++) begin
         instr_address = addrs[i];
         #1;
         vectors++;
         if (instr_readdata !== exp[i]) begin
            errors++;
            $display("FAIL window[%h]: got %h want %h", addrs[i], instr_readdata, exp[i]);
         end
      end
   endtask

   task automatic test_clk_enable();
      expected_v0   = 32'hFFFE0017;
      register_v0   = 32'hFFFE0017;
      start_run();
      clk_enable    = 1'b1;
      active        = 1'b1;
      instr_address = BASE;
      // load attempt while running must be dropped
      load_en   = 1'b1;
      load_addr = 6'd63;
      load_data = 32'h12345678;
      tick();
      load_en = 1'b0;
      start   = 1'b1;          // start while running must be ignored
      tick();
      start   = 1'b0;
      tick();
      vectors++;
      if (cycle_count !== 16'd3) begin
         errors++;
         $display("FAIL pre_stall_count: got %0d want 3", cycle_count);
      end
      clk_enable    = 1'b0;
      instr_address = 32'h0;
      active        = 1'b0;
      repeat (10) tick();
      vectors++;
      if (cycle_count !== 16'd3 || done !== 1'b0) begin
         errors++;
         $display("FAIL stall_frozen: got cnt=%0d done=%b want cnt=3 done=0", cycle_count, done);
      end
      instr_address = BASE + 32'd252;
      #1;
      vectors++;
      if (instr_readdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL load_in_run: got %h want deadbeef", instr_readdata);
      end
      clk_enable    = 1'b1;
      active        = 1'b1;
      instr_address = BASE;
      tick();
      tick();
      vectors++;
      if (cycle_count !== 16'd5) begin
         errors++;
         $display("FAIL resume_count: got %0d want 5", cycle_count);
      end
      instr_address = 32'h0;
      tick();
      tick();
      vectors++;
      if ({done, pass, fail} !== 3'b110 || cycle_count !== 16'd6) begin
         errors++;
         $display("FAIL stall_result: got d/p/f=%b%b%b cnt=%0d want 110 cnt=6", done, pass, fail, cycle_count);
      end
   endtask

`ifdef MIPS_MON_TIMEOUT_EN
   task automatic test_timeout();
      int n;
      load_word(0, 32'h0BF00000);   // j 0xBFC00000
      register_v0   = 32'h0;
      expected_v0   = 32'h0;
      start_run();
      clk_enable    = 1'b1;
      active        = 1'b1;
      instr_address = BASE;
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      vectors++;
      if ({done, pass, fail} !== 3'b101 || cycle_count !== 16'd19 || n != 19) begin
         errors++;
         $display("FAIL timeout: got d/p/f=%b%b%b cnt=%0d edges=%0d want 101 cnt=19 edges=19",
                  done, pass, fail, cycle_count, n);
      end
   endtask
`endif

   task automatic test_reset_mid_run();
      load_word(0, 32'h24020001);
      start_run();
      clk_enable    = 1'b1;
      active        = 1'b1;
      instr_address = BASE;
      repeat (4) tick();
      vectors++;
      if (cycle_count !== 16'd4 || instr_readdata !== 32'h24020001) begin
         errors++;
         $display("FAIL pre_reset: got cnt=%0d rom=%h want cnt=4 rom=24020001", cycle_count, instr_readdata);
      end
      #2;
      reset = 1'b1;
      #1;
      vectors++;
      if ({done, pass, fail} !== 3'b000 || cycle_count !== 16'd0 || instr_readdata !== 32'h0) begin
         errors++;
         $display("FAIL async_reset: got d/p/f=%b%b%b cnt=%0d rom=%h want 000 cnt=0 rom=0",
                  done, pass, fail, cycle_count, instr_readdata);
      end
      tick();
      reset = 1'b0;
      // back in IDLE: a fresh start and immediate halt completes in one counted cycle
      start_run();
      instr_address = 32'h0;
      tick();
      tick();
      vectors++;
      if ({done, pass, fail} !== 3'b110 || cycle_count !== 16'd1) begin
         errors++;
         $display("FAIL after_reset_run: got d/p/f=%b%b%b cnt=%0d want 110 cnt=1", done, pass, fail, cycle_count);
      end
   endtask

   initial begin
      test_reset();
      test_addu_pass();
      test_addu_fail();
      test_fetch_window();
      test_clk_enable();
`ifdef MIPS_MON_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule : tb_mips_prog_monitor
`default_nettype wire
